// File: rtl/ycc_block_frontend_pkg.sv
//============================================================================
// Module : jpeg_pre_pkg
// Brief  : Shared types, conversion coefficients and helpers for the YCbCr
//          block front end.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package jpeg_pre_pkg;

    // Widest component the beat structure can carry.
    localparam int c_max_dw = 16;

    typedef struct packed {
        logic [c_max_dw-1:0] y;
        logic [c_max_dw-1:0] cb;
        logic [c_max_dw-1:0] cr;
        logic                chroma_en;
        logic                blk_start;
        logic                blk_end;
    } ycc_beat_t;

    // round(num/den * 2^frac), rounding half away from zero.
    function automatic int coef(input longint num, input longint den, input int frac);
        longint mag;
        mag = (num < 0) ? -num : num;
        mag = ((mag << frac) + den / 2) / den;
        return (num < 0) ? -int'(mag) : int'(mag);
    endfunction

    function automatic int coef_y_r (input int frac); return coef( 299,    1000,    frac); endfunction
    function automatic int coef_y_g (input int frac); return coef( 587,    1000,    frac); endfunction
    function automatic int coef_y_b (input int frac); return coef( 114,    1000,    frac); endfunction
    function automatic int coef_cb_r(input int frac); return coef(-168736, 1000000, frac); endfunction
    function automatic int coef_cb_g(input int frac); return coef(-331264, 1000000, frac); endfunction
    function automatic int coef_cb_b(input int frac); return coef( 5,      10,      frac); endfunction
    function automatic int coef_cr_r(input int frac); return coef( 5,      10,      frac); endfunction
    function automatic int coef_cr_g(input int frac); return coef(-418688, 1000000, frac); endfunction
    function automatic int coef_cr_b(input int frac); return coef(-81312,  1000000, frac); endfunction

    // Clamp a signed value into the unsigned range of a dw-bit component.
    function automatic logic [c_max_dw-1:0] saturate(input longint v, input int dw);
        longint hi;
        hi = (longint'(1) <<< dw) - 1;
        if (v < 0)  return '0;
        if (v > hi) return c_max_dw'(hi);
        return c_max_dw'(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ycc_block_frontend_if.sv
//============================================================================
// Module : ycc_block_frontend_if
// Brief  : Pixel-in / YCbCr-out handshake bundle of the block front end.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface ycc_block_frontend_if #(
    parameter int DATA_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [3*DATA_W-1:0] in_rgb;
    logic                mode_gray;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_y;
    logic [DATA_W-1:0]   out_cb;
    logic [DATA_W-1:0]   out_cr;
    logic                out_chroma_en;
    logic                out_blk_start;
    logic                out_blk_end;

    // slave: the front end itself; master: pixel source plus channel chains.
    modport slave (
        input  in_valid, in_rgb, mode_gray, out_ready,
        output in_ready, out_valid, out_y, out_cb, out_cr,
               out_chroma_en, out_blk_start, out_blk_end
    );

    modport master (
        output in_valid, in_rgb, mode_gray, out_ready,
        input  in_ready, out_valid, out_y, out_cb, out_cr,
               out_chroma_en, out_blk_start, out_blk_end
    );
endinterface

`default_nettype wire

// File: rtl/ycc_block_frontend_convert_pipe.sv
//============================================================================
// Module : ycc_convert_pipe
// Brief  : 3-stage fixed-point RGB to YCbCr datapath with a shared stage
//          enable; valid and framing tags shift alongside the data.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module ycc_convert_pipe
    import jpeg_pre_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_FRAC = 14
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_en,
    input  wire logic                i_valid,
    input  wire logic [3*DATA_W-1:0] i_rgb,
    input  wire logic                i_gray,
    input  wire logic                i_blk_start,
    input  wire logic                i_blk_end,
    output logic                     o_valid,
    output ycc_beat_t                o_beat
);

    localparam int c_iw = DATA_W + COEF_FRAC + 3;
    typedef logic signed [c_iw-1:0] acc_t;

    // Row-major: Y, Cb, Cr rows; R, G, B columns.
    localparam acc_t c_coef [9] = '{
        acc_t'(coef_y_r (COEF_FRAC)), acc_t'(coef_y_g (COEF_FRAC)), acc_t'(coef_y_b (COEF_FRAC)),
        acc_t'(coef_cb_r(COEF_FRAC)), acc_t'(coef_cb_g(COEF_FRAC)), acc_t'(coef_cb_b(COEF_FRAC)),
        acc_t'(coef_cr_r(COEF_FRAC)), acc_t'(coef_cr_g(COEF_FRAC)), acc_t'(coef_cr_b(COEF_FRAC))
    };
    localparam acc_t                c_round = acc_t'(1) <<< (COEF_FRAC - 1);
    localparam acc_t                c_off   = acc_t'(1) <<< (DATA_W - 1 + COEF_FRAC);
    localparam logic [c_max_dw-1:0] c_mid   = c_max_dw'(1) << (DATA_W - 1);

    acc_t                w_px   [3];
    acc_t                r_prod [9];
    acc_t                r_sum  [3];
    logic [c_max_dw-1:0] w_sat  [3];
    logic [2:0]          r_tag1;
    logic [2:0]          r_tag2;
    logic                r_v1;
    logic                r_v2;

    for (genvar k = 0; k < 3; k++) begin : g_px
        assign w_px[k] = acc_t'(i_rgb[(3-k)*DATA_W-1 -: DATA_W]);
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_sat[c] = saturate(longint'(r_sum[c] >>> COEF_FRAC), DATA_W);
        end
    end

    // Tag bits: [2] gray, [1] block start, [0] block end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            o_valid <= 1'b0;
            r_tag1  <= '0;
            r_tag2  <= '0;
            o_beat  <= '0;
            for (int i = 0; i < 9; i++) r_prod[i] <= '0;
            for (int i = 0; i < 3; i++) r_sum[i]  <= '0;
        end else if (i_en) begin
            r_v1   <= i_valid;
            r_tag1 <= {i_gray, i_blk_start, i_blk_end};
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < 3; k++) begin
                    r_prod[3*c+k] <= w_px[k] * c_coef[3*c+k];
                end
            end

            r_v2     <= r_v1;
            r_tag2   <= r_tag1;
            r_sum[0] <= r_prod[0] + r_prod[1] + r_prod[2] + c_round;
            r_sum[1] <= r_prod[3] + r_prod[4] + r_prod[5] + c_off + c_round;
            r_sum[2] <= r_prod[6] + r_prod[7] + r_prod[8] + c_off + c_round;

            o_valid          <= r_v2;
            o_beat.y         <= w_sat[0];
            o_beat.cb        <= r_tag2[2] ? c_mid : w_sat[1];
            o_beat.cr        <= r_tag2[2] ? c_mid : w_sat[2];
            o_beat.chroma_en <= ~r_tag2[2];
            o_beat.blk_start <= r_tag2[1];
            o_beat.blk_end   <= r_tag2[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ycc_block_frontend.sv
//============================================================================
// Module : ycc_block_frontend
// Brief  : RGB block front end: handshake, block framing, per-block gray
//          mode latch and completed-block counter around the YCbCr pipe.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module ycc_block_frontend
    import jpeg_pre_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_FRAC = 14,
    parameter int BLK_PIX   = 64,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ycc_block_frontend_if.slave   bus,
    output logic [CNT_W-1:0]      blocks_done
);

    localparam int                c_idx_w = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(BLK_PIX - 1);

    logic               w_stall;
    logic               w_en;
    logic               w_in_fire;
    logic               w_first;
    logic               w_gray;
    logic               w_valid;
    ycc_beat_t          w_beat;
    logic [c_idx_w-1:0] r_in_idx;
    logic               r_mode;

    // Whole pipeline advances together; a stalled output blocks the input.
    assign w_stall      = w_valid & ~bus.out_ready;
    assign w_en         = ~w_stall;
    assign bus.in_ready = w_en;
    assign w_in_fire    = bus.in_valid & w_en;

    // Mode is taken live on pixel 0 and held for the rest of the block.
    assign w_first = (r_in_idx == '0);
    assign w_gray  = w_first ? bus.mode_gray : r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_idx <= '0;
            r_mode   <= 1'b0;
        end else if (w_in_fire) begin
            r_in_idx <= (r_in_idx == c_last) ? '0 : r_in_idx + 1'b1;
            if (w_first) r_mode <= bus.mode_gray;
        end
    end

    ycc_convert_pipe #(
        .DATA_W    (DATA_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_en),
        .i_valid     (bus.in_valid),
        .i_rgb       (bus.in_rgb),
        .i_gray      (w_gray),
        .i_blk_start (w_first),
        .i_blk_end   (r_in_idx == c_last),
        .o_valid     (w_valid),
        .o_beat      (w_beat)
    );

    assign bus.out_valid     = w_valid;
    assign bus.out_y         = w_beat.y[DATA_W-1:0];
    assign bus.out_cb        = w_beat.cb[DATA_W-1:0];
    assign bus.out_cr        = w_beat.cr[DATA_W-1:0];
    assign bus.out_chroma_en = w_beat.chroma_en;
    assign bus.out_blk_start = w_beat.blk_start;
    assign bus.out_blk_end   = w_beat.blk_end;

    // Upper lanes of the shared beat type are always zero at this width.
    if (DATA_W < c_max_dw) begin : g_pad
        logic w_unused;
        assign w_unused = ^{w_beat.y[c_max_dw-1:DATA_W], w_beat.cb[c_max_dw-1:DATA_W],
                            w_beat.cr[c_max_dw-1:DATA_W]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_done <= '0;
        end else if (w_valid && bus.out_ready && w_beat.blk_end) begin
            blocks_done <= blocks_done + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ycc_block_frontend.sv
//============================================================================
// Module : tb_ycc_block_frontend
// Brief  : Scoreboard bench for the YCbCr block front end.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_ycc_block_frontend;

    localparam int c_big = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] blocks_done;

    ycc_block_frontend_if #(.DATA_W(8)) bus_if ();

    ycc_block_frontend #(
        .DATA_W    (8),
        .COEF_FRAC (14),
        .BLK_PIX   (64),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer coefficients of 0.299/0.587/0.114 etc. at 2^14.
    function automatic logic [26:0] ref_beat(input logic [23:0] rgb, input bit gray,
                                             input bit st, input bit en);
        int r, g, b, y, cb, cr;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        b  = int'(rgb[7:0]);
        y  = (4899 * r + 9617 * g + 1868 * b + 8192) >>> 14;
        cb = (8192 * b - 2765 * r - 5427 * g + 2097152 + 8192) >>> 14;
        cr = (8192 * r - 6860 * g - 1332 * b + 2097152 + 8192) >>> 14;
        y  = (y  > 255) ? 255 : (y  < 0) ? 0 : y;
        cb = (cb > 255) ? 255 : (cb < 0) ? 0 : cb;
        cr = (cr > 255) ? 255 : (cr < 0) ? 0 : cr;
        if (gray) begin
            cb = 128;
            cr = 128;
        end
        return {y[7:0], cb[7:0], cr[7:0], ~gray, st, en};
    endfunction

    logic [26:0] exp_q[$];
    int          m_idx;
    bit          m_mode;
    int          exp_blocks;

    // Monitor: sample mid-cycle, describing what the next rising edge does.
    initial begin
        bit          g;
        logic [26:0] got;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_idx      = 0;
                m_mode     = 1'b0;
                exp_blocks = 0;
            end else begin
                chk("blocks_done", 32'(blocks_done), 32'(exp_blocks));
                chk("in_ready", 32'(bus_if.in_ready),
                    32'(!(bus_if.out_valid && !bus_if.out_ready)));
                if (bus_if.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", 32'(exp_q.size()), 32'd1);
                    end else begin
                        got = {bus_if.out_y, bus_if.out_cb, bus_if.out_cr,
                               bus_if.out_chroma_en, bus_if.out_blk_start, bus_if.out_blk_end};
                        chk("beat", 32'(got), 32'(exp_q[0]));
                        if (bus_if.out_ready) begin
                            if (exp_q[0][0]) exp_blocks++;
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (bus_if.in_valid && bus_if.in_ready) begin
                    g = (m_idx == 0) ? bus_if.mode_gray : m_mode;
                    if (m_idx == 0) m_mode = g;
                    exp_q.push_back(ref_beat(bus_if.in_rgb, g, m_idx == 0, m_idx == 63));
                    m_idx = (m_idx + 1) % 64;
                end
            end
        end
    end

    // All tasks below start and end at rising edge + 2.
    task automatic single(input logic [23:0] rgb, input logic [7:0] ey, input logic [7:0] ecb,
                          input logic [7:0] ecr, input bit est);
        int cnt;
        bus_if.in_valid  = 1'b1;
        bus_if.in_rgb    = rgb;
        bus_if.mode_gray = 1'b0;
        @(posedge clk); #2;
        bus_if.in_valid = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus_if.out_valid && cnt < 20);
        chk("latency", 32'(cnt), 32'd3);
        chk("px_y", 32'(bus_if.out_y), 32'(ey));
        chk("px_cb", 32'(bus_if.out_cb), 32'(ecb));
        chk("px_cr", 32'(bus_if.out_cr), 32'(ecr));
        chk("px_chroma_en", 32'(bus_if.out_chroma_en), 32'd1);
        chk("px_blk_start", 32'(bus_if.out_blk_start), 32'(est));
        @(posedge clk); #2;
    endtask

    task automatic drive(input int n, input int gray_from, input int stall_at);
        int          sent = 0;
        int          cyc  = 0;
        bit          acc;
        logic [23:0] px   = 24'($urandom);
        while (sent < n && cyc < 4 * n + 50) begin
            bus_if.in_valid  = 1'b1;
            bus_if.in_rgb    = px;
            bus_if.mode_gray = (sent >= gray_from);
            bus_if.out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            @(negedge clk);
            acc = bus_if.in_ready;
            @(posedge clk); #2;
            cyc++;
            if (acc) begin
                sent++;
                px = 24'($urandom);
            end
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        chk("drive_done", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        bus_if.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_rgb    = '0;
        bus_if.mode_gray = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_out_ycc", 32'({bus_if.out_y, bus_if.out_cb, bus_if.out_cr}), 32'd0);
        chk("rst_flags", 32'({bus_if.out_chroma_en, bus_if.out_blk_start, bus_if.out_blk_end}), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_blocks", 32'(blocks_done), 32'd0);
        @(posedge clk); #2;

        single(24'hFFFFFF, 8'd255, 8'd128, 8'd128, 1'b1);
        single(24'hFF0000, 8'd76,  8'd85,  8'd255, 1'b0);
        single(24'h000000, 8'd0,   8'd128, 8'd128, 1'b0);

        // Full block back to back from a clean start.
        pulse_reset();
        drive(64, c_big, -1);
        drain();
        chk("blocks_after_blk", 32'(blocks_done), 32'd1);

        // Five-cycle downstream stall in mid-block.
        drive(64, c_big, 20);
        drain();

        // Gray requested at pixel 10: only the following block goes gray.
        drive(128, 10, -1);
        drain();
        chk("blocks_after_gray", 32'(blocks_done), 32'd4);

        // Reset with a full pipeline.
        drive(30, c_big, -1);
        pulse_reset();
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("midrst_blocks", 32'(blocks_done), 32'd0);
        @(posedge clk); #2;
        drive(64, c_big, -1);
        drain();
        chk("blocks_after_rst", 32'(blocks_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
